// File: rtl/ling_wide_add_seq.sv
// Byte-serial W-bit adder on a shared external 8-bit Ling adder; `LING_SEQ_SUB_EN adds op_sub (A-B).
// Latency: accept edge + NBYTES RUN cycles, result valid the cycle after; one op per NBYTES+2 cycles.
// Backpressure: out_ready low holds DONE with result stable and in_ready low.
module ling_wide_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  op_cin,
`ifdef LING_SEQ_SUB_EN
  input  logic                  op_sub,
`endif
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout
);

  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IW-1:0]          idx;
  logic                   carry_reg;
  logic [NBYTES-1:0][7:0] a_reg;
  logic [NBYTES-1:0][7:0] b_reg;
  logic [NBYTES-1:0][7:0] res_reg;
  logic                   cout_reg;
  logic                   last;
  logic [8*NBYTES-1:0]    b_in;
  logic                   cin_in;

  assign last = (idx == LAST);

  // Subtraction is A + ~B + 1, so only the latched B and initial carry differ.
`ifdef LING_SEQ_SUB_EN
  assign b_in   = op_sub ? ~op_b : op_b;
  assign cin_in = op_sub ? 1'b1  : op_cin;
`else
  assign b_in   = op_b;
  assign cin_in = op_cin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The shared adder sees zeros outside RUN so it idles between operations.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 8'd0;
    add_b     = 8'd0;
    add_cin   = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_RUN: begin
        add_a   = a_reg[idx];
        add_b   = b_reg[idx];
        add_cin = carry_reg;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= b_in;
            carry_reg <= cin_in;
            idx       <= '0;
          end
        end
        S_RUN: begin
          res_reg[idx] <= add_sum;
          carry_reg    <= add_cout;
          if (last) begin
            cout_reg <= add_cout;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign result = res_reg;
  assign cout   = cout_reg;

endmodule

// File: tb/tb_ling_wide_add_seq.sv
// Bench for ling_wide_add_seq: behavioural 8-bit adder on the add_* ports, arithmetic reference model.
module tb_ling_wide_add_seq;
  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         op_sub;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = 9'(add_a) + 9'(add_b) + 9'(add_cin);

  ling_wide_add_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
`ifdef LING_SEQ_SUB_EN
    .op_sub    (op_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout)
  );

  // Full-width sum {cout, result} = a + b + cin.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  // Carry entering byte k = bit 8k of the sum of the low 8k bits of each operand.
  function automatic logic ref_carry(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int k);
    logic [63:0] m;
    logic [63:0] s;
    m = (64'd1 << (8 * k)) - 64'd1;
    s = (64'(a) & m) + (64'(b) & m) + 64'(cin);
    return s[8*k];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set for exactly the accept edge, then scrambles the inputs.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    op_cin   = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
    checks++; if ({add_a, add_b, add_cin} !== 17'd0) begin errors++; $display("FAIL reset_adder_idle got %h/%h/%b want 0", add_a, add_b, add_cin); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ops(input int n, input logic [W-1:0] fa, input logic [W-1:0] fb, input logic fc, input bit fixed);
    logic [W-1:0] a, b;
    logic c;
    logic [W:0] exp;
    for (int i = 0; i < n; i++) begin
      a = fixed ? fa : W'($urandom);
      b = fixed ? fb : W'($urandom);
      c = fixed ? fc : 1'($urandom);
      exp = ref_sum(a, b, c);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL op_ready_before got %b want 1", in_ready); end
      start_op(a, b, c);
      for (int k = 0; k < NBYTES; k++) begin
        checks++; if (add_cin !== ref_carry(a, b, c, k)) begin errors++; $display("FAIL run_add_cin byte %0d got %b want %b", k, add_cin, ref_carry(a, b, c, k)); end
        checks++; if (add_a !== a[8*k+:8] || add_b !== b[8*k+:8]) begin errors++; $display("FAIL run_add_ab byte %0d got %h/%h want %h/%h", k, add_a, add_b, a[8*k+:8], b[8*k+:8]); end
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL run_flags byte %0d got rdy %b vld %b want 0 0", k, in_ready, out_valid); end
        step();
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL done_out_valid got %b want 1", out_valid); end
      checks++; if ({cout, result} !== exp) begin errors++; $display("FAIL op_sum %h+%h+%b got %b_%h want %b_%h", a, b, c, cout, result, exp[W], exp[W-1:0]); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %b want 0", in_ready); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL after_handshake got vld %b rdy %b want 0 1", out_valid, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    repeat (NBYTES) step();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold cyc %0d got vld %b rdy %b want 1 0", i, out_valid, in_ready); end
      checks++; if (result !== 32'h0000_0100 || cout !== 1'b0) begin errors++; $display("FAIL bp_result cyc %0d got %b_%h want 0_00000100", i, cout, result); end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got vld %b rdy %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_run();
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || cout !== 1'b0) begin errors++; $display("FAIL midrst_flags got vld %b cout %b want 0 0", out_valid, cout); end
    checks++; if (result !== '0) begin errors++; $display("FAIL midrst_result got %h want 0", result); end
    step();
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got rdy %b vld %b want 1 0", in_ready, out_valid); end
    start_op(32'd3, 32'd4, 1'b0);
    repeat (NBYTES) step();
    checks++; if (out_valid !== 1'b1 || result !== 32'd7 || cout !== 1'b0) begin errors++; $display("FAIL midrst_follow got vld %b %b_%h want 1 0_00000007", out_valid, cout, result); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va[3];
    logic [W-1:0] vb[3];
    logic         vc[3];
    logic [W:0]   exp;
    int acc_c[$];
    int out_c[$];
    int sent = 0;
    int got = 0;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; vc[0] = 1'b1;
    for (int i = 1; i < 3; i++) begin
      va[i] = $urandom; vb[i] = $urandom; vc[i] = 1'($urandom);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 3; c++) begin
      if (out_valid === 1'b1) begin
        exp = ref_sum(va[got], vb[got], vc[got]);
        checks++; if ({cout, result} !== exp) begin errors++; $display("FAIL stream_sum %0d got %b_%h want %b_%h", got, cout, result, exp[W], exp[W-1:0]); end
        out_c.push_back(c);
        got++;
      end
      if (in_ready === 1'b1 && sent < 3) begin
        op_a = va[sent]; op_b = vb[sent]; op_cin = vc[sent];
        in_valid = 1'b1;
        acc_c.push_back(c);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (got != 3) begin errors++; $display("FAIL stream_count got %0d want 3", got); end
    for (int i = 0; i < got; i++) begin
      checks++; if (out_c[i] - acc_c[i] != NBYTES + 1) begin errors++; $display("FAIL stream_latency %0d got %0d want %0d", i, out_c[i] - acc_c[i], NBYTES + 1); end
      if (i > 0) begin
        checks++; if (out_c[i] - out_c[i-1] != NBYTES + 2) begin errors++; $display("FAIL stream_spacing %0d got %0d want %0d", i, out_c[i] - out_c[i-1], NBYTES + 2); end
      end
    end
  endtask

`ifdef LING_SEQ_SUB_EN
  task automatic test_sub();
    logic [W-1:0] a, b;
    logic [W:0]   exp;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 32'd5 : (i == 1) ? 32'd7 : W'($urandom);
      b = (i == 0) ? 32'd7 : (i == 1) ? 32'd5 : W'($urandom);
      exp = ref_sum(a, ~b, 1'b1);
      op_sub = 1'b1;
      start_op(a, b, 1'($urandom));
      op_sub = 1'($urandom);
      repeat (NBYTES) step();
      checks++; if (out_valid !== 1'b1 || {cout, result} !== exp) begin errors++; $display("FAIL sub %h-%h got vld %b %b_%h want 1 %b_%h", a, b, out_valid, cout, result, exp[W], exp[W-1:0]); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    op_sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_ops(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    test_ops(1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);
    test_ops(20, '0, '0, 1'b0, 1'b0);
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef LING_SEQ_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ling_wide_add_seq.md
Name: ling_wide_add_seq

Overview:
- Byte-serial sequencer that performs NBYTES×8-bit additions on a single shared 8-bit combinational Ling adder.
- Carry is chained between passes, one byte per cycle, LSB first.
- Operands enter through a valid/ready handshake; the result leaves through a valid/ready handshake.
- Sits between a wide-operand producer and the 8-bit adder instance, which is connected externally through the add_* ports.

Parameters:
NBYTES, 4, number of 8-bit passes; operand width W = 8*NBYTES; legal range 2..16

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand transfer request
in_ready  out  1  sequencer can accept operands
op_a  in  W  addend A
op_b  in  W  addend B
op_cin  in  1  carry-in to byte 0
add_a  out  8  byte of A to the adder
add_b  out  8  byte of B to the adder
add_cin  out  1  carry into the adder
add_sum  in  8  adder sum (combinational, same cycle)
add_cout  in  1  adder carry-out (combinational, same cycle)
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  W  registered sum
cout  out  1  registered final carry-out

Behaviour:
- Reset state: FSM=IDLE; idx=0; carry_reg=0; a_reg, b_reg and result cleared to 0; out_valid=0; cout=0. in_ready=1 immediately on reset assertion.
- Reset is asynchronous and takes priority in every state. Reset mid-RUN discards the operation: no out_valid, no partial result visible.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a_reg=op_a, b_reg=op_b, carry_reg=op_cin, idx=0, then go to RUN.
  - result and cout keep their previous values.
- RUN:
  - in_ready=0.
  - add_a = a_reg[8*idx+:8], add_b = b_reg[8*idx+:8], add_cin = carry_reg.
  - At the clock edge: result[8*idx+:8] <= add_sum; carry_reg <= add_cout.
  - If idx==NBYTES-1: cout <= add_cout, go to DONE. Otherwise idx <= idx+1.
- DONE:
  - out_valid=1; result and cout stable.
  - On out_ready: go to IDLE and drop out_valid.
  - Back-to-back acceptance is not allowed: the first in_ready after completion is the cycle after the handshake.
- Outside RUN, add_a, add_b and add_cin are driven 0 so the shared adder idles.
- Latency:
  - accept edge → NBYTES RUN cycles → out_valid high in the cycle after the last RUN edge.
  - Throughput is one operation per NBYTES+2 cycles when out_ready is held high.
- Arithmetic:
  - {cout, result} = op_a + op_b + op_cin, modulo 2^(W+1).
  - Overflow is not flagged.
- Operand stability: op_a, op_b and op_cin are sampled only at the accept edge; changes afterwards have no effect.
- Back-pressure: out_ready low holds DONE indefinitely, with result stable and in_ready low.
- idx width is clog2(NBYTES). idx never exceeds NBYTES-1.

Optional Feature:
- Macro: LING_SEQ_SUB_EN.
- When defined:
  - Adds input op_sub (1 bit), sampled at the accept edge with the operands.
  - When op_sub=1: b_reg latches ~op_b and carry_reg latches 1 (op_cin ignored).
  - Result is op_a - op_b; cout=1 means no borrow.
  - When op_sub=0: behaviour is identical to the base block.
- When undefined: the op_sub port does not exist and the block is add-only.

Test Plan:
- NBYTES=4, op_a=0xFFFFFFFF, op_b=0x00000001, op_cin=0 → out_valid 5 cycles after the accept edge; result=0x00000000, cout=1; add_cin observed as 0,1,1,1 across the RUN cycles.
- op_a=0x12345678, op_b=0x11111111, op_cin=1 → result=0x2345678A, cout=0; in_ready low from the accept edge until the cycle after the output handshake.
- Back-pressure: complete op_a=0x000000FF + op_b=0x00000001 while holding out_ready=0 for 10 cycles → out_valid and result=0x00000100 stable for all 10 cycles; in_valid pulses are ignored; release → return to IDLE the next cycle.
- Assert rst during the second RUN cycle of 0xFFFFFFFF+0x1 → out_valid and cout go 0 immediately; result=0; in_ready=1 after release; a following 3+4 yields 0x00000007, cout=0.
- Streaming with out_ready tied to 1: three back-to-back valid operations → each result spaced exactly NBYTES+2 cycles apart, all sums correct.
- With LING_SEQ_SUB_EN defined: op_sub=1, op_a=5, op_b=7 → result=0xFFFFFFFE, cout=0. op_sub=1, op_a=7, op_b=5 → result=0x00000002, cout=1.
